// File: rtl/leg_ctrl_pkg.sv
// Shared types and constants for the LEG instruction sequencer.
package leg_ctrl_pkg;

  localparam int OP_IMM_A    = 7;
  localparam int OP_IMM_B    = 6;
  localparam int OP_COND     = 5;
  localparam int ALU_OP_W    = 3;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RD_A,
    S_RD_A_W,
    S_RD_B,
    S_RD_B_W,
    S_EXEC,
    S_RETIRE
  } state_e;

endpackage

// File: rtl/leg_operand_mode_decode.sv
// Opcode classification: which operands come from the register file, and branch vs ALU class.
module leg_operand_mode_decode
  import leg_ctrl_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       need_rd_a,
  output logic       need_rd_b,
  output logic       is_cond
);

  assign need_rd_a = !opcode[OP_IMM_A];
  assign need_rd_b = !opcode[OP_IMM_B];
  assign is_cond   = opcode[OP_COND];

  // Reserved and ALU-op bits play no part in the operand mode.
  logic unused_bits;
  assign unused_bits = ^opcode[4:0];

endmodule

// File: rtl/leg_instr_sequencer.sv
// Multi-cycle LEG control FSM: byte-wide fetch, up to two shared-port register reads,
// ALU/condition capture, then writeback or branch.
module leg_instr_sequencer
  import leg_ctrl_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         REG_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              prog_req,
  output logic [7:0]        prog_addr,
  input  logic              prog_ack,
  input  logic [7:0]        prog_data,
  output logic              reg_rd_en,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [7:0]        reg_rd_data,
  output logic [2:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  input  logic              cond_true,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  output logic [7:0]        pc,
  output logic              busy,
  output logic              instr_done
);

  state_e state_q, state_d;
  logic [1:0] idx_q;
  logic [INSTR_BYTES-1:0][7:0] instr_q;
  logic taken_q;
  logic need_rd_a, need_rd_b, is_cond;

  logic [7:0] opcode, arg1, arg2, dest;
  assign opcode = instr_q[0];
  assign arg1   = instr_q[1];
  assign arg2   = instr_q[2];
  assign dest   = instr_q[3];

  leg_operand_mode_decode u_mode (
    .opcode    (opcode),
    .need_rd_a (need_rd_a),
    .need_rd_b (need_rd_b),
    .is_cond   (is_cond)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    prog_req   = 1'b0;
    reg_rd_en  = 1'b0;
    reg_wr_en  = 1'b0;
    instr_done = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        prog_req = 1'b1;
        if (prog_ack && idx_q == 2'd3) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (need_rd_a)      state_d = S_RD_A;
        else if (need_rd_b) state_d = S_RD_B;
        else                state_d = S_EXEC;
      end
      S_RD_A: begin
        reg_rd_en = 1'b1;
        state_d   = S_RD_A_W;
      end
      S_RD_A_W: state_d = need_rd_b ? S_RD_B : S_EXEC;
      S_RD_B: begin
        reg_rd_en = 1'b1;
        state_d   = S_RD_B_W;
      end
      S_RD_B_W: state_d = S_EXEC;
      S_EXEC:   state_d = S_RETIRE;
      S_RETIRE: begin
        reg_wr_en  = !is_cond;
        instr_done = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_addr   = pc + {6'd0, idx_q};
  assign reg_rd_addr = (state_q == S_RD_B) ? arg2[REG_AW-1:0] : arg1[REG_AW-1:0];
  assign reg_wr_addr = dest[REG_AW-1:0];
  assign alu_op      = opcode[ALU_OP_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= PC_RESET;
      idx_q       <= 2'd0;
      instr_q     <= '0;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      reg_wr_data <= 8'h00;
      taken_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: idx_q <= 2'd0;
        S_FETCH: if (prog_ack) begin
          instr_q[idx_q] <= prog_data;
          idx_q          <= idx_q + 2'd1;
        end
        S_DECODE: begin
          if (opcode[OP_IMM_A]) alu_a <= arg1;
          if (opcode[OP_IMM_B]) alu_b <= arg2;
        end
        S_RD_A_W: alu_a <= reg_rd_data;
        S_RD_B_W: alu_b <= reg_rd_data;
        S_EXEC: begin
          reg_wr_data <= alu_result;
          taken_q     <= cond_true;
        end
        S_RETIRE: begin
          idx_q <= 2'd0;
          pc    <= (is_cond && taken_q) ? dest : pc + 8'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
